eprisc_bus_pipeline: RTL and testbench

//  Parametrised byte-serial host bus slave: the second-generation front end of the I/O controller.

---
 rtl/eprisc_bus_pipeline.sv | 176 +++++++++++++++++
 tb/tb_eprisc_bus_pipeline.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/eprisc_bus_pipeline.sv
// Byte-serial host bus slave: assembles command frames, decodes them into device windows,
// runs a strobe/ready handshake with timeout, and combines masked device interrupts.
module eprisc_bus_pipeline #(
    parameter int WORD_BYTES    = 4,
    parameter int ADDR_BITS     = 15,
    parameter int NUM_DEV       = 4,
    parameter int DEV_SPAN_LOG2 = 4,
    parameter int TIMEOUT       = 15
) (
    input  logic                                          iClk,
    input  logic                                          iRst,
    input  logic                                          iBusSelect,
    input  logic [7:0]                                    iBusMOSI,
    output logic [7:0]                                    oBusMISO,
    output logic                                          oBusBusy,
    output logic                                          oBusInterrupt,
    output logic [NUM_DEV-1:0]                            oDevStrobe,
    output logic                                          oDevWrite,
    output logic [ADDR_BITS-1:0]                          oDevAddr,
    output logic [8*WORD_BYTES-ADDR_BITS-2:0]             oDevData,
    input  logic [NUM_DEV*(8*WORD_BYTES-ADDR_BITS-1)-1:0] iDevRdata,
    input  logic [NUM_DEV-1:0]                            iDevReady,
    input  logic [NUM_DEV-1:0]                            iDevIrq
);

    localparam int W         = 8 * WORD_BYTES;
    localparam int DATA_BITS = W - 1 - ADDR_BITS;
    localparam int CNT_W     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int TMR_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, SHIFT, EXEC, WAIT, DONE} state_t;

    logic                            wInternalReset;
    state_t                          state;
    logic [CNT_W-1:0]                byteCnt;
    logic [WORD_BYTES-1:0][7:0]      cmdBuf;
    logic [WORD_BYTES-1:0][7:0]      respReg;
    logic [NUM_DEV-1:0]              maskReg;
    logic [TMR_W-1:0]                waitCnt;

    logic [W-1:0]                    cmdWord;
    logic                            cmdWrite;
    logic [ADDR_BITS-1:0]            cmdAddr;
    logic [DATA_BITS-1:0]            cmdData;
    logic [ADDR_BITS-1:0]            devIdx;
    logic                            isCtrl;
    logic                            isMapped;
    logic [NUM_DEV-1:0]              decodeStrobe;
    logic                            readyHit;
    logic [DATA_BITS-1:0]            rdataSel;
    logic [DATA_BITS-1:0]            maskRd;

    function automatic logic [W-1:0] makeResponse(input logic err, input logic vld,
                                                  input logic [DATA_BITS-1:0] rd);
        logic [W-1:0] r;
        r                = '0;
        r[W-1]           = err;
        r[W-2]           = vld;
        r[DATA_BITS-1:0] = rd;
        return r;
    endfunction

    assign wInternalReset = iRst;

    assign cmdWord      = cmdBuf;
    assign cmdWrite     = cmdWord[W-1];
    assign cmdAddr      = cmdWord[W-2 -: ADDR_BITS];
    assign cmdData      = cmdWord[DATA_BITS-1:0];
    assign devIdx       = cmdAddr >> DEV_SPAN_LOG2;
    assign isCtrl       = &cmdAddr;
    assign isMapped     = (32'(devIdx) < 32'(NUM_DEV));
    assign decodeStrobe = NUM_DEV'(1) << devIdx;

    // The strobe is one-hot while waiting, so it doubles as the ready/read-data selector.
    assign readyHit = |(iDevReady & oDevStrobe);

    always_comb begin
        rdataSel = '0;
        for (int d = 0; d < NUM_DEV; d++) begin
            if (oDevStrobe[d]) begin
                rdataSel = rdataSel | iDevRdata[d*DATA_BITS +: DATA_BITS];
            end
        end
    end

    always_comb begin
        maskRd              = '0;
        maskRd[NUM_DEV-1:0] = maskReg;
    end

    always_comb begin
        oBusMISO = 8'h00;
        if (state == IDLE || state == SHIFT) begin
            oBusMISO = respReg[byteCnt];
        end
    end

    always_ff @(posedge iClk or posedge wInternalReset) begin
        if (wInternalReset) begin
            state         <= IDLE;
            byteCnt       <= '0;
            cmdBuf        <= '0;
            respReg       <= '0;
            maskReg       <= '0;
            waitCnt       <= '0;
            oBusBusy      <= 1'b0;
            oBusInterrupt <= 1'b0;
            oDevStrobe    <= '0;
            oDevWrite     <= 1'b0;
            oDevAddr      <= '0;
            oDevData      <= '0;
        end else begin
            oBusInterrupt <= |(iDevIrq & maskReg);
            case (state)
                IDLE, SHIFT: begin
                    if (iBusSelect) begin
                        cmdBuf[byteCnt] <= iBusMOSI;
                        if (byteCnt == CNT_W'(WORD_BYTES - 1)) begin
                            byteCnt  <= '0;
                            state    <= EXEC;
                            oBusBusy <= 1'b1;
                        end else begin
                            byteCnt <= byteCnt + 1'b1;
                            state   <= SHIFT;
                        end
                    end else begin
                        // Select dropped mid-frame: discard the partial command.
                        byteCnt <= '0;
                        state   <= IDLE;
                    end
                end
                EXEC: begin
                    if (isCtrl) begin
                        if (cmdWrite) begin
                            maskReg <= cmdData[NUM_DEV-1:0];
                        end
                        respReg <= makeResponse(1'b0, 1'b1, cmdWrite ? {DATA_BITS{1'b0}} : maskRd);
                        state   <= DONE;
                    end else if (isMapped) begin
                        oDevStrobe <= decodeStrobe;
                        oDevWrite  <= cmdWrite;
                        oDevAddr   <= cmdAddr;
                        oDevData   <= cmdData;
                        waitCnt    <= '0;
                        state      <= WAIT;
                    end else begin
                        respReg <= makeResponse(1'b1, 1'b0, {DATA_BITS{1'b0}});
                        state   <= DONE;
                    end
                end
                WAIT: begin
                    if (readyHit) begin
                        respReg    <= makeResponse(1'b0, 1'b1, oDevWrite ? {DATA_BITS{1'b0}} : rdataSel);
                        oDevStrobe <= '0;
                        state      <= DONE;
                    end else if (waitCnt == TMR_W'(TIMEOUT - 1)) begin
                        respReg    <= makeResponse(1'b1, 1'b0, {DATA_BITS{1'b0}});
                        oDevStrobe <= '0;
                        state      <= DONE;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                DONE: begin
                    // Host must release select before the next frame can start.
                    if (!iBusSelect) begin
                        oBusBusy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eprisc_bus_pipeline.sv
// Directed bench for eprisc_bus_pipeline: frame transactions with hand-computed responses.
module tb_eprisc_bus_pipeline;

    localparam int NUM_DEV   = 4;
    localparam int ADDR_BITS = 15;
    localparam int DATA_BITS = 16;

    logic                           iClk = 1'b0;
    logic                           iRst;
    logic                           iBusSelect;
    logic [7:0]                     iBusMOSI;
    logic [7:0]                     oBusMISO;
    logic                           oBusBusy;
    logic                           oBusInterrupt;
    logic [NUM_DEV-1:0]             oDevStrobe;
    logic                           oDevWrite;
    logic [ADDR_BITS-1:0]           oDevAddr;
    logic [DATA_BITS-1:0]           oDevData;
    logic [NUM_DEV*DATA_BITS-1:0]   iDevRdata;
    logic [NUM_DEV-1:0]             iDevReady;
    logic [NUM_DEV-1:0]             iDevIrq;

    int assertCount = 0;
    int failCount   = 0;

    eprisc_bus_pipeline dut (
        .iClk          (iClk),
        .iRst          (iRst),
        .iBusSelect    (iBusSelect),
        .iBusMOSI      (iBusMOSI),
        .oBusMISO      (oBusMISO),
        .oBusBusy      (oBusBusy),
        .oBusInterrupt (oBusInterrupt),
        .oDevStrobe    (oDevStrobe),
        .oDevWrite     (oDevWrite),
        .oDevAddr      (oDevAddr),
        .oDevData      (oDevData),
        .iDevRdata     (iDevRdata),
        .iDevReady     (iDevReady),
        .iDevIrq       (iDevIrq)
    );

    always #5 iClk = ~iClk;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Shifts one frame in (LSB byte first) and collects the response bytes seen on MISO.
    task automatic sendFrame(input logic [31:0] word, output logic [31:0] misoWord);
        misoWord = '0;
        for (int b = 0; b < 4; b++) begin
            @(negedge iClk);
            misoWord[8*b +: 8] = oBusMISO;
            iBusSelect = 1'b1;
            iBusMOSI   = word[8*b +: 8];
        end
        @(negedge iClk);
        iBusSelect = 1'b0;
        iBusMOSI   = 8'h00;
    endtask

    // Follows one access until busy clears; ready is raised on the readyCycle-th strobe cycle.
    task automatic runAccess(input int readyCycle, input logic [3:0] readyMask, input logic [3:0] otherReady,
                             output int strobeCycles, output logic [3:0] strobeOr,
                             output logic [31:0] firstAddr, output logic [31:0] firstData,
                             output logic firstWrite, output logic finished);
        strobeCycles = 0;
        strobeOr     = '0;
        firstAddr    = '0;
        firstData    = '0;
        firstWrite   = 1'b0;
        finished     = 1'b0;
        iDevReady    = otherReady;
        for (int i = 0; i < 40 && !finished; i++) begin
            @(negedge iClk);
            if (oDevStrobe != '0) begin
                strobeCycles++;
                strobeOr = strobeOr | oDevStrobe;
                if (strobeCycles == 1) begin
                    firstAddr  = 32'(oDevAddr);
                    firstData  = 32'(oDevData);
                    firstWrite = oDevWrite;
                end
                iDevReady = (strobeCycles == readyCycle) ? readyMask : otherReady;
            end else if (!oBusBusy) begin
                finished = 1'b1;
            end else begin
                iDevReady = otherReady;
            end
        end
        iDevReady = '0;
    endtask

    logic [31:0] miso;
    int          cycles;
    logic [3:0]  strobes;
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
    logic        fin;

    initial begin
        iRst       = 1'b1;
        iBusSelect = 1'b0;
        iBusMOSI   = 8'h00;
        iDevReady  = '0;
        iDevIrq    = '0;
        iDevRdata  = {16'h3333, 16'hBEEF, 16'h1111, 16'h0A0A};

        #12;
        checkValue("rstMiso", 32'(oBusMISO), 32'h0);
        checkValue("rstBusy", 32'(oBusBusy), 32'h0);
        checkValue("rstStrobe", 32'(oDevStrobe), 32'h0);
        checkValue("rstIrq", 32'(oBusInterrupt), 32'h0);
        checkValue("rstAddr", 32'(oDevAddr), 32'h0);
        @(negedge iClk);
        iRst = 1'b0;

        // Write 0x1234 to device 1, ready on the first wait cycle.
        sendFrame(32'h80101234, miso);
        checkValue("t1Miso", miso, 32'h0000_0000);
        runAccess(1, 4'b0010, 4'b0100, cycles, strobes, addr, data, wr, fin);
        checkValue("t1Cycles", 32'(cycles), 32'd1);
        checkValue("t1Strobe", 32'(strobes), 32'h2);
        checkValue("t1Addr", addr, 32'h0010);
        checkValue("t1Data", data, 32'h1234);
        checkValue("t1Write", 32'(wr), 32'h1);
        checkValue("t1Done", 32'(fin), 32'h1);

        // Read device 2, ready on third wait cycle, other devices' ready asserted as noise.
        sendFrame(32'h00210000, miso);
        checkValue("t2Miso", miso, 32'h4000_0000);
        runAccess(3, 4'b0100, 4'b1011, cycles, strobes, addr, data, wr, fin);
        checkValue("t2Cycles", 32'(cycles), 32'd3);
        checkValue("t2Strobe", 32'(strobes), 32'h4);
        checkValue("t2Addr", addr, 32'h0021);
        checkValue("t2Write", 32'(wr), 32'h0);

        // Unmapped device 5.
        sendFrame(32'h00500000, miso);
        checkValue("t3Miso", miso, 32'h4000_BEEF);
        runAccess(1, 4'b1111, 4'b1111, cycles, strobes, addr, data, wr, fin);
        checkValue("t3Cycles", 32'(cycles), 32'd0);
        checkValue("t3Done", 32'(fin), 32'h1);

        // Device 0 never ready: timeout after 15 strobe cycles.
        sendFrame(32'h00030000, miso);
        checkValue("t4Miso", miso, 32'h8000_0000);
        runAccess(0, 4'b0001, 4'b1110, cycles, strobes, addr, data, wr, fin);
        checkValue("t4Cycles", 32'(cycles), 32'd15);
        checkValue("t4Strobe", 32'(strobes), 32'h1);

        // Aborted frame after two bytes.
        @(negedge iClk);
        iBusSelect = 1'b1;
        iBusMOSI   = 8'hAA;
        @(negedge iClk);
        iBusMOSI   = 8'hBB;
        @(negedge iClk);
        iBusSelect = 1'b0;
        iBusMOSI   = 8'h00;
        for (int k = 0; k < 3; k++) begin
            @(negedge iClk);
            checkValue("abortBusy", 32'(oBusBusy), 32'h0);
            checkValue("abortStrobe", 32'(oDevStrobe), 32'h0);
        end
        sendFrame(32'h8030CAFE, miso);
        checkValue("t5Miso", miso, 32'h8000_0000);
        runAccess(2, 4'b1000, 4'b0111, cycles, strobes, addr, data, wr, fin);
        checkValue("t5Cycles", 32'(cycles), 32'd2);
        checkValue("t5Strobe", 32'(strobes), 32'h8);
        checkValue("t5Addr", addr, 32'h0030);
        checkValue("t5Data", data, 32'hCAFE);

        // Mask write then interrupt combine.
        sendFrame(32'hFFFF0005, miso);
        checkValue("t6Miso", miso, 32'h4000_0000);
        runAccess(1, 4'b1111, 4'b0000, cycles, strobes, addr, data, wr, fin);
        checkValue("t6Cycles", 32'(cycles), 32'd0);
        iDevIrq = 4'b0010;
        @(negedge iClk);
        checkValue("irqMasked", 32'(oBusInterrupt), 32'h0);
        iDevIrq = 4'b0100;
        checkValue("irqLatency", 32'(oBusInterrupt), 32'h0);
        @(negedge iClk);
        checkValue("irqActive", 32'(oBusInterrupt), 32'h1);

        // Mask readback.
        sendFrame(32'h7FFF0000, miso);
        checkValue("ctrlWrMiso", miso, 32'h4000_0000);
        runAccess(1, 4'b1111, 4'b0000, cycles, strobes, addr, data, wr, fin);
        checkValue("ctrlCycles", 32'(cycles), 32'd0);

        // Asynchronous reset in the middle of a wait.
        sendFrame(32'h00100000, miso);
        checkValue("ctrlRdMiso", miso, 32'h4000_0005);
        @(negedge iClk);
        checkValue("preRstStrobe", 32'(oDevStrobe), 32'h2);
        #2 iRst = 1'b1;
        #1;
        checkValue("asyncStrobe", 32'(oDevStrobe), 32'h0);
        checkValue("asyncBusy", 32'(oBusBusy), 32'h0);
        checkValue("asyncIrq", 32'(oBusInterrupt), 32'h0);
        @(negedge iClk);
        iRst = 1'b0;
        @(negedge iClk);
        checkValue("postRstIrq", 32'(oBusInterrupt), 32'h0);
        checkValue("postRstMiso", 32'(oBusMISO), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
